// File: rtl/serial_mag_comparator_ctrl_pkg.sv
// Shared definitions for the serial magnitude comparator: state encoding
// and the helper that sizes the bit-index counter.
package serial_mag_comparator_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // Bit-index counter width; a 1-bit operand still needs a 1-bit counter.
  function automatic int calcCntW(input int width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_mag_comparator_ctrl_cmp_bit_cell.sv
// Single-bit magnitude comparator cell. Purely combinational; exactly one
// of bgt/beq/blt is high for any input pair.
module cmp_bit_cell (
  input  logic x,
  input  logic y,
  output logic bgt,
  output logic beq,
  output logic blt
);

  assign bgt = x & ~y;
  assign blt = ~x & y;
  assign beq = ~(x ^ y);

endmodule

// File: rtl/serial_mag_comparator_ctrl.sv
// Serial unsigned magnitude comparator. Operands are captured on an accepted
// start and walked MSB first through one cmp_bit_cell, one bit per clock.
// Optional macro SERIAL_CMP_EARLY_EXIT_EN: when defined, the compare ends on
// the first differing bit; otherwise it always takes WIDTH cycles and the
// first decision is frozen while the remaining bits are stepped through.
module serial_mag_comparator_ctrl
  import serial_mag_comparator_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int CNT_W = calcCntW(WIDTH);
  localparam logic [CNT_W-1:0] IDX_MAX = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CNT_W-1:0] r_idx;
  logic             r_decided;
  logic             r_seenGt;
  logic             r_seenLt;
  logic             r_gt;
  logic             r_eq;
  logic             r_lt;

  logic             w_bitA;
  logic             w_bitB;
  logic             w_bgt;
  logic             w_beq;
  logic             w_blt;
  logic             w_lastBit;
  logic             w_newDecision;
  logic             w_exitCompare;
  logic             w_finalGt;
  logic             w_finalEq;
  logic             w_finalLt;

  assign w_bitA = r_a[r_idx];
  assign w_bitB = r_b[r_idx];

  cmp_bit_cell u_cell (
    .x   (w_bitA),
    .y   (w_bitB),
    .bgt (w_bgt),
    .beq (w_beq),
    .blt (w_blt)
  );

  assign w_lastBit     = (r_idx == '0);
  assign w_newDecision = !w_beq && !r_decided;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  assign w_exitCompare = !w_beq || w_lastBit;
`else
  assign w_exitCompare = w_lastBit;
`endif

  // The first decision wins; if none was made before this bit, the cell decides now.
  assign w_finalGt = r_decided ? r_seenGt : w_bgt;
  assign w_finalLt = r_decided ? r_seenLt : w_blt;
  assign w_finalEq = !r_decided && w_beq;

  assign busy = (r_state != ST_IDLE);
  assign done = (r_state == ST_DONE);
  assign gt   = r_gt;
  assign eq   = r_eq;
  assign lt   = r_lt;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: IDLE waits for start, COMPARE runs until its exit bit, DONE lasts one cycle.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_nextState = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        if (w_exitCompare) begin
          w_nextState = ST_DONE;
        end
      end
      ST_DONE: begin
        w_nextState = ST_IDLE;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // Operand capture, bit-index countdown, decision tracking and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_idx     <= '0;
      r_decided <= 1'b0;
      r_seenGt  <= 1'b0;
      r_seenLt  <= 1'b0;
      r_gt      <= 1'b0;
      r_eq      <= 1'b0;
      r_lt      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a       <= a;
            r_b       <= b;
            r_idx     <= IDX_MAX;
            r_decided <= 1'b0;
            r_seenGt  <= 1'b0;
            r_seenLt  <= 1'b0;
            r_gt      <= 1'b0;
            r_eq      <= 1'b0;
            r_lt      <= 1'b0;
          end
        end
        ST_COMPARE: begin
          if (w_newDecision) begin
            r_decided <= 1'b1;
            r_seenGt  <= w_bgt;
            r_seenLt  <= w_blt;
          end
          if (w_exitCompare) begin
            r_gt <= w_finalGt;
            r_eq <= w_finalEq;
            r_lt <= w_finalLt;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mag_comparator_ctrl.sv
// Self-checking bench for serial_mag_comparator_ctrl: table of directed
// 8-bit compares plus hand-written busy-ignore, mid-compare reset and
// 1-bit back-to-back sequences.
module tb_serial_mag_comparator_ctrl;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  localparam int EARLY = 1;
`else
  localparam int EARLY = 0;
`endif

  logic       clk;
  logic       rst;

  logic       start8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       busy8, done8, gt8, eq8, lt8;

  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       busy1, done1, gt1, eq1, lt1;

  int nChecks = 0;
  int nFails  = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       gt;
    logic       eq;
    logic       lt;
    int         m;
  } vec_t;

  vec_t vecs[8];

  serial_mag_comparator_ctrl #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .busy  (busy8),
    .done  (done8),
    .gt    (gt8),
    .eq    (eq8),
    .lt    (lt8)
  );

  serial_mag_comparator_ctrl #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst   (rst),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .busy  (busy1),
    .done  (done1),
    .gt    (gt1),
    .eq    (eq1),
    .lt    (lt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv);
    start8 = 1'b1;
    a8     = av;
    b8     = bv;
  endtask

  // One full compare on the 8-bit DUT: start in c0, expect done in c0+m+1.
  task automatic runCompare8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                             input logic eg, input logic ee, input logic el, input int m);
    int doneAt;
    nextCycle();
    checkOutput({tag, "_idleBusy"}, busy8, 0);
    applyStimulus(av, bv);
    nextCycle();
    start8 = 1'b0;
    a8     = ~av;
    b8     = ~bv;
    doneAt = 0;
    for (int k = 1; k <= 40 && doneAt == 0; k++) begin
      if (done8) begin
        doneAt = k;
      end else begin
        checkOutput({tag, "_busyMid"}, busy8, 1);
        checkOutput({tag, "_resultMid"}, {gt8, eq8, lt8}, 3'b000);
        nextCycle();
      end
    end
    checkOutput({tag, "_doneCycle"}, doneAt, m + 1);
    checkOutput({tag, "_busyDone"}, busy8, 1);
    checkOutput({tag, "_gt"}, gt8, eg);
    checkOutput({tag, "_eq"}, eq8, ee);
    checkOutput({tag, "_lt"}, lt8, el);
    nextCycle();
    checkOutput({tag, "_doneAfter"}, done8, 0);
    checkOutput({tag, "_busyAfter"}, busy8, 0);
    checkOutput({tag, "_resultHeld"}, {gt8, eq8, lt8}, {eg, ee, el});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int nDone;
    int doneAt;
    logic [2:0] res;

    vecs[0] = '{8'hA5, 8'hA5, 1'b0, 1'b1, 1'b0, 8};
    vecs[1] = '{8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, (EARLY != 0) ? 1 : 8};
    vecs[2] = '{8'h3C, 8'h3D, 1'b0, 1'b0, 1'b1, 8};
    vecs[3] = '{8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, (EARLY != 0) ? 1 : 8};
    vecs[4] = '{8'hFF, 8'hFE, 1'b1, 1'b0, 1'b0, 8};
    vecs[5] = '{8'h12, 8'h10, 1'b1, 1'b0, 1'b0, (EARLY != 0) ? 7 : 8};
    vecs[6] = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8};
    vecs[7] = '{8'h5A, 8'hA5, 1'b0, 1'b0, 1'b1, (EARLY != 0) ? 1 : 8};

    rst    = 1'b1;
    start8 = 1'b0;
    a8     = 8'h00;
    b8     = 8'h00;
    start1 = 1'b0;
    a1     = 1'b0;
    b1     = 1'b0;

    nextCycle();
    nextCycle();
    checkOutput("reset8", {busy8, done8, gt8, eq8, lt8}, 5'b0);
    checkOutput("reset1", {busy1, done1, gt1, eq1, lt1}, 5'b0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      runCompare8($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                  vecs[i].gt, vecs[i].eq, vecs[i].lt, vecs[i].m);
    end

    // Start pulsed during COMPARE must be ignored.
    nextCycle();
    applyStimulus(8'h3C, 8'h3D);
    nextCycle();
    start8 = 1'b0;
    nDone  = 0;
    doneAt = 0;
    res    = 3'b000;
    for (int k = 1; k <= 14; k++) begin
      if (k == 3) applyStimulus(8'h00, 8'hFF);
      if (k == 4) start8 = 1'b0;
      if (done8) begin
        nDone++;
        doneAt = k;
        res    = {gt8, eq8, lt8};
      end
      nextCycle();
    end
    checkOutput("ignore_doneCount", nDone, 1);
    checkOutput("ignore_doneCycle", doneAt, 9);
    checkOutput("ignore_result", res, 3'b001);
    checkOutput("ignore_idle", busy8, 0);
    checkOutput("ignore_resultHeld", {gt8, eq8, lt8}, 3'b001);

    // Reset asserted in c0+3 aborts the compare with no done pulse.
    nextCycle();
    applyStimulus(8'hA5, 8'hA5);
    nextCycle();
    start8 = 1'b0;
    nextCycle();
    nextCycle();
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    checkOutput("abort_outputs", {busy8, done8, gt8, eq8, lt8}, 5'b0);
    nDone = 0;
    for (int k = 0; k < 12; k++) begin
      if (done8) nDone++;
      nextCycle();
    end
    checkOutput("abort_noDone", nDone, 0);
    runCompare8("afterAbort", 8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, (EARLY != 0) ? 1 : 8);

    // WIDTH=1 back-to-back with start held high.
    nextCycle();
    start1 = 1'b1;
    a1     = 1'b1;
    b1     = 1'b0;
    nextCycle();
    a1 = 1'b0;
    b1 = 1'b1;
    checkOutput("b2b_c1", {busy1, done1, gt1, eq1, lt1}, 5'b10000);
    nextCycle();
    checkOutput("b2b_c2", {busy1, done1, gt1, eq1, lt1}, 5'b11100);
    nextCycle();
    checkOutput("b2b_c3", {busy1, done1, gt1, eq1, lt1}, 5'b00100);
    nextCycle();
    checkOutput("b2b_c4", {busy1, done1, gt1, eq1, lt1}, 5'b10000);
    nextCycle();
    checkOutput("b2b_c5", {busy1, done1, gt1, eq1, lt1}, 5'b11001);
    start1 = 1'b0;
    nextCycle();
    checkOutput("b2b_c6", {busy1, done1, gt1, eq1, lt1}, 5'b00001);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
